atari_bus_initiator: RTL and testbench
======================================

# atari_bus_initiator

Synthesizable Atari 7800 system-side bus initiator. It generates PHI2 and performs single 6502-style read and write cycles, plus MARIA-style DMA read cycles (HALT low), from a valid/ready command stream. It lets a second FPGA drive a cartridge board's edge connector for hardware-in-loop testing of ROM decode, POKEY writes and $2200 control without a console. It sits between a host command source (UART or test sequencer) and the cartridge bus pins.

## Interface
Parameters:
- PHI2_DIV, 15: system clocks per PHI2 period (27 MHz / 15 = 1.8 MHz). Legal range is ≥4.
- PHI2_LOW, 8: clocks of PHI2 low phase; the high phase is PHI2_DIV−PHI2_LOW. Legal range is 2..PHI2_DIV−2.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this clk when cmd_valid=1
- cmd_rw  in  1  1 = read, 0 = write
- cmd_dma  in  1  1 = DMA cycle (HALT low); ignored for writes, which are never DMA
- cmd_addr  in  16  bus address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-clk pulse per completed command
- rsp_rdata  out  8  captured read data; 8'h00 for writes
- a  out  16  address bus
- phi2  out  1  phase-2 clock
- rw  out  1  read/write
- halt  out  1  HALT, active low
- d_out  out  8  write data to pad
- d_oe  out  1  pad output enable for d
- d_in  in  8  data bus input from pad
- cycle_count  out  32  completed command cycles, wraps at 2^32

## Operation
- The phase counter runs 0..PHI2_DIV−1 and wraps continuously. PHI2 is free-running in both idle and busy states, because the console clock never stops.
- phi2 = 0 for phases 0..PHI2_LOW−1 and 1 for phases PHI2_LOW..PHI2_DIV−1.
- cmd_ready = 1 only at phase PHI2_DIV−1. A handshake there loads a, rw, halt and d_out, which take effect at phase 0 of the next period.
- Idle period (no handshake): a holds its last value, rw=1, halt=1, d_oe=0.
- Read: rw=1 for the whole period. d_in is sampled at phase PHI2_DIV−1, the last clk with phi2 high.
- Write: rw=0 for the whole period. d_oe=1 for phases PHI2_LOW..PHI2_DIV−1 only, so data is never driven while phi2 is low. d_out is held for the whole period.
- DMA read: same as a read but with halt=0 for that period. halt returns to 1 at the next period unless the next command is also DMA, in which case halt stays 0 continuously.
- Back-to-back commands produce zero idle periods.
- cycle_count increments at phase 0 of the period after each command period.

State machine:
- IDLE → RD, WR or DMA on a handshake.
- Each state returns to IDLE at PHI2_DIV−1, or goes directly to the next command state on a new handshake.

## Timing
- Reset values: phase=0, phi2=0, a=16'h0000, rw=1, halt=1, d_oe=0, d_out=8'h00, cmd_ready=0, rsp_valid=0, rsp_rdata=8'h00, cycle_count=0.
- Command latency: a handshake at phase PHI2_DIV−1 puts the bus cycle in the next PHI2_DIV clks. rsp_valid pulses at phase 0 of the period after that, 1 clk wide, together with rsp_rdata.
- rsp_valid (phase 0) and cmd_ready (phase PHI2_DIV−1) never coincide, given the legal PHI2_DIV range.
- Reset mid-cycle takes effect on the next clk edge: the cycle is aborted, d_oe=0, no rsp_valid is produced, and cycle_count is not incremented.
- cmd_* inputs are ignored outside phase PHI2_DIV−1.
- All bus outputs are registered, with no combinational paths from cmd_* to pins.

## Structure
- Package atari_bus_pkg:
  - default PHI2_DIV and PHI2_LOW
  - address window constants: ROM_BASE 16'h4000, POKEY_BASE 16'h0450 with mask 16'hFFF0, MENU_CTRL 16'h2200
  - state enum {IDLE, RD, WR, DMA}
- Sub-module phi2_phase_gen: phase counter, phi2, and the last_phase and first_phase strobes.

## Test plan
- Reset: hold reset_n=0 for 20 clks, then release. Outputs match the reset values, and phi2 toggles with period 15 (8 clks low, 7 high).
- Read: cmd rd at 16'h4000, with the responder driving d_in=8'hA9 during phi2 high. a=4000, rw=1, halt=1 for 15 clks; rsp_valid pulse with rsp_rdata=8'hA9; cycle_count=1.
- Write: cmd wr at 16'h0450, wdata 8'h5A. rw=0 for 15 clks; d_oe=1 only at phases 8..14 with d_out=5A; rsp_valid with rdata 00.
- Back-to-back: a DMA read at 16'h8000 followed by a DMA read at 16'h8001. halt=0 continuously for 30 clks with no idle period; two rsp pulses 15 clks apart; halt=1 afterwards.
- Reset mid-write: reset_n=0 at phase 10 of a write to 16'h2200. d_oe=0 and rw=1 on the next clk, no rsp_valid, cycle_count unchanged.
- Wrap: preload cycle_count to 32'hFFFF_FFFF via force, then complete one read. cycle_count=0.

Source files
------------

// File: rtl/atari_bus_pkg.sv
// Shared constants and types for the Atari 7800 system-side bus initiator.
package atari_bus_pkg;

    localparam int PHI2_DIV_DEF = 15;
    localparam int PHI2_LOW_DEF = 8;

    localparam logic [15:0] ROM_BASE   = 16'h4000;
    localparam logic [15:0] POKEY_BASE = 16'h0450;
    localparam logic [15:0] POKEY_MASK = 16'hFFF0;
    localparam logic [15:0] MENU_CTRL  = 16'h2200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DMA  = 2'd3
    } state_t;

endpackage

// File: rtl/phi2_phase_gen.sv
// Free-running PHI2 phase counter with registered phi2 and period strobes.
module phi2_phase_gen #(
    parameter int PHI2_DIV = 15,
    parameter int PHI2_LOW = 8,
    parameter int PW       = $clog2(PHI2_DIV)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [PW-1:0] phase,
    output logic [PW-1:0] phase_nxt,
    output logic          phi2,
    output logic          first_phase,
    output logic          last_phase
);

    logic [PW-1:0] phase_q, phase_d;
    logic          phi2_q, phi2_d;

    assign last_phase  = (phase_q == PW'(PHI2_DIV - 1));
    assign first_phase = (phase_q == '0);

    // phi2 is registered from the next phase so it lines up with phase_q.
    always_comb begin
        phase_d = last_phase ? '0 : phase_q + PW'(1);
        phi2_d  = (phase_d >= PW'(PHI2_LOW));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= '0;
            phi2_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            phi2_q  <= phi2_d;
        end
    end

    assign phase     = phase_q;
    assign phase_nxt = phase_d;
    assign phi2      = phi2_q;

endmodule

// File: rtl/atari_bus_initiator.sv
// Atari 7800 bus initiator: PHI2 generation, 6502 read/write and MARIA-style DMA reads.
module atari_bus_initiator
    import atari_bus_pkg::*;
#(
    parameter int PHI2_DIV = PHI2_DIV_DEF,
    parameter int PHI2_LOW = PHI2_LOW_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic        cmd_dma,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] a,
    output logic        phi2,
    output logic        rw,
    output logic        halt,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    output logic [31:0] cycle_count
);

    localparam int PW = $clog2(PHI2_DIV);

    logic [PW-1:0] phase, phase_nxt;
    logic          first_phase, last_phase;

    phi2_phase_gen #(
        .PHI2_DIV (PHI2_DIV),
        .PHI2_LOW (PHI2_LOW),
        .PW       (PW)
    ) u_phase (
        .clk         (clk),
        .reset_n     (reset_n),
        .phase       (phase),
        .phase_nxt   (phase_nxt),
        .phi2        (phi2),
        .first_phase (first_phase),
        .last_phase  (last_phase)
    );

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic        rw_q, rw_d;
    logic        halt_q, halt_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic [31:0] cycle_count_q, cycle_count_d;

    assign cmd_ready = last_phase;

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        rw_d          = rw_q;
        halt_d        = halt_q;
        d_out_d       = d_out_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        cycle_count_d = cycle_count_q;

        if (first_phase) begin
            rsp_valid_d = 1'b0;
        end

        // Period boundary: retire the current cycle and load the next one.
        if (last_phase) begin
            rsp_valid_d = (state_q != IDLE);
            if (state_q != IDLE) begin
                rsp_rdata_d   = (state_q == WR) ? 8'h00 : d_in;
                cycle_count_d = cycle_count_q + 32'd1;
            end

            if (cmd_valid) begin
                a_d    = cmd_addr;
                rw_d   = cmd_rw;
                halt_d = !(cmd_rw && cmd_dma);
                if (!cmd_rw) begin
                    d_out_d = cmd_wdata;
                    state_d = WR;
                end else if (cmd_dma) begin
                    state_d = DMA;
                end else begin
                    state_d = RD;
                end
            end else begin
                rw_d    = 1'b1;
                halt_d  = 1'b1;
                state_d = IDLE;
            end
        end

        // Pad is only driven while phi2 is high in a write period.
        d_oe_d = (state_d == WR) && (phase_nxt >= PW'(PHI2_LOW));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            a_q           <= 16'h0000;
            rw_q          <= 1'b1;
            halt_q        <= 1'b1;
            d_out_q       <= 8'h00;
            d_oe_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            cycle_count_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            rw_q          <= rw_d;
            halt_q        <= halt_d;
            d_out_q       <= d_out_d;
            d_oe_q        <= d_oe_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign a           = a_q;
    assign rw          = rw_q;
    assign halt        = halt_q;
    assign d_out       = d_out_q;
    assign d_oe        = d_oe_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_atari_bus_initiator.sv
// Self-checking bench for atari_bus_initiator: per-clock period model plus directed sequences.
module tb_atari_bus_initiator;
    import atari_bus_pkg::*;

    localparam int DIV = 15;
    localparam int LOW = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_rw = 1'b1;
    logic        cmd_dma = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        cmd_ready, rsp_valid, phi2, rw, halt, d_oe;
    logic [7:0]  rsp_rdata, d_out, d_in;
    logic [15:0] a;
    logic [31:0] cycle_count;

    atari_bus_initiator #(.PHI2_DIV(DIV), .PHI2_LOW(LOW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_dma     (cmd_dma),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .a           (a),
        .phi2        (phi2),
        .rw          (rw),
        .halt        (halt),
        .d_out       (d_out),
        .d_oe        (d_oe),
        .d_in        (d_in),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Cartridge responder: valid data only while phi2 is high, inverted otherwise.
    function automatic logic [7:0] resp_of(input logic [15:0] ad);
        return ad[7:0] ^ ad[15:8] ^ 8'hE9;
    endfunction
    assign d_in = phi2 ? resp_of(a) : ~resp_of(a);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // Period-level reference model: which command owns the current PHI2 period.
    int          exp_phase = 0;
    logic        cur_valid = 1'b0, cur_rw = 1'b1, cur_dma = 1'b0;
    logic [15:0] exp_a = 16'h0000;
    logic [7:0]  exp_dout = 8'h00, exp_rdata = 8'h00;
    logic        exp_rsp = 1'b0;
    logic [31:0] exp_count = 32'd0;
    logic [31:0] count_adj = 32'd0;
    bit          check_en = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            exp_phase <= 0;
            cur_valid <= 1'b0;
            exp_a     <= 16'h0000;
            exp_dout  <= 8'h00;
            exp_rdata <= 8'h00;
            exp_rsp   <= 1'b0;
            exp_count <= 32'd0;
        end else begin
            exp_rsp <= 1'b0;
            if (exp_phase == DIV - 1) begin
                exp_phase <= 0;
                if (cur_valid) begin
                    exp_rsp   <= 1'b1;
                    exp_rdata <= cur_rw ? resp_of(exp_a) : 8'h00;
                    exp_count <= exp_count + 32'd1;
                end
                cur_valid <= cmd_valid;
                if (cmd_valid) begin
                    cur_rw  <= cmd_rw;
                    cur_dma <= cmd_dma & cmd_rw;
                    exp_a   <= cmd_addr;
                    if (!cmd_rw) exp_dout <= cmd_wdata;
                end
            end else begin
                exp_phase <= exp_phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("phi2", 32'(phi2), 32'(exp_phase >= LOW));
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_phase == DIV - 1));
            chk("a", 32'(a), 32'(exp_a));
            chk("rw", 32'(rw), 32'(cur_valid ? cur_rw : 1'b1));
            chk("halt", 32'(halt), 32'((cur_valid && cur_dma) ? 1'b0 : 1'b1));
            chk("d_oe", 32'(d_oe), 32'(cur_valid && !cur_rw && (exp_phase >= LOW)));
            chk("d_out", 32'(d_out), 32'(exp_dout));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            chk("cycle_count", cycle_count, exp_count + count_adj);
        end
    end

    // Caller is at a negedge; handshake lands on the edge that ends phase DIV-1.
    task automatic issue(input logic rw_i, input logic dma_i, input logic [15:0] ad, input logic [7:0] wd);
        int n = 0;
        while (exp_phase != DIV - 1 && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (exp_phase != DIV - 1) timeout_fail("issue_wait");
        cmd_valid = 1'b1;
        cmd_rw    = rw_i;
        cmd_dma   = dma_i;
        cmd_addr  = ad;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) timeout_fail("rsp_wait");
    endtask

    typedef struct {
        logic        rw;
        logic        dma;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        exp_rw;
        logic        exp_halt;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ones;
        int lows;
        int rsp_seen;
        int first_rsp;
        logic [31:0] cnt0;

        vt[0] = '{1'b1, 1'b0, ROM_BASE,                 8'h00, 1'b1, 1'b1, 8'hA9};
        vt[1] = '{1'b0, 1'b0, POKEY_BASE,               8'h5A, 1'b0, 1'b1, 8'h00};
        vt[2] = '{1'b1, 1'b1, 16'h8000,                 8'h00, 1'b1, 1'b0, 8'h69};
        vt[3] = '{1'b0, 1'b1, MENU_CTRL,                8'h33, 1'b0, 1'b1, 8'h00};
        vt[4] = '{1'b1, 1'b0, POKEY_BASE,               8'hFF, 1'b1, 1'b1, 8'hBD};
        vt[5] = '{1'b0, 1'b0, POKEY_BASE | ~POKEY_MASK, 8'hC3, 1'b0, 1'b1, 8'h00};

        // Reset held for 20 clocks.
        @(posedge clk);
        #1 check_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_phi2", 32'(phi2), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rw_halt", {30'd0, rw, halt}, 32'd3);
        reset_n = 1'b1;
        ones = 0;
        for (int i = 0; i < DIV; i++) begin
            if (phi2) ones++;
            @(negedge clk);
        end
        chk("phi2_high_clks", 32'(ones), 32'(DIV - LOW));

        // Reset in the middle of a write.
        issue(1'b0, 1'b0, MENU_CTRL, 8'h77);
        repeat (10) @(negedge clk);
        chk("midwr_doe_before", 32'(d_oe), 32'd1);
        cnt0 = cycle_count;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midwr_doe", 32'(d_oe), 32'd0);
        chk("midwr_rw", 32'(rw), 32'd1);
        chk("midwr_count", cycle_count, cnt0);
        reset_n = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            if (rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        chk("midwr_no_rsp", 32'(rsp_seen), 32'd0);

        // Table of isolated commands.
        foreach (vt[i]) begin
            cnt0 = cycle_count;
            issue(vt[i].rw, vt[i].dma, vt[i].addr, vt[i].wdata);
            repeat (5) @(negedge clk);
            chk("vec_a", 32'(a), 32'(vt[i].addr));
            chk("vec_rw", 32'(rw), 32'(vt[i].exp_rw));
            chk("vec_halt", 32'(halt), 32'(vt[i].exp_halt));
            chk("vec_doe_low", 32'(d_oe), 32'd0);
            repeat (LOW - 5) @(negedge clk);
            chk("vec_doe_high", 32'(d_oe), 32'(!vt[i].rw));
            if (!vt[i].rw) chk("vec_dout", 32'(d_out), 32'(vt[i].wdata));
            wait_rsp();
            chk("vec_rdata", 32'(rsp_rdata), 32'(vt[i].exp_rdata));
            chk("vec_count", cycle_count, cnt0 + 32'd1);
        end

        // Back-to-back DMA reads keep HALT low with no idle period.
        repeat (2 * DIV) @(negedge clk);
        issue(1'b1, 1'b1, 16'h8000, 8'h00);
        lows = 0;
        first_rsp = -1;
        for (int i = 0; i < 2 * DIV; i++) begin
            if (!halt) lows++;
            if (rsp_valid && first_rsp < 0) first_rsp = i;
            if (exp_phase == DIV - 1 && i < DIV) begin
                cmd_valid = 1'b1;
                cmd_rw    = 1'b1;
                cmd_dma   = 1'b1;
                cmd_addr  = 16'h8001;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_halt_low", 32'(lows), 32'(2 * DIV));
        chk("b2b_rsp1_pos", 32'(first_rsp), 32'(DIV));
        chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata2", 32'(rsp_rdata), 32'h68);
        chk("b2b_halt_after", 32'(halt), 32'd1);

        // Random traffic, including noise outside phase DIV-1 and rare resets.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_rw    = 1'($urandom_range(0, 1));
            cmd_dma   = 1'($urandom_range(0, 1));
            cmd_addr  = 16'($urandom);
            cmd_wdata = 8'($urandom);
            reset_n   = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        reset_n   = 1'b1;
        repeat (3 * DIV) @(negedge clk);

        // cycle_count wrap.
        @(posedge clk);
        #1 check_en = 1'b0;
        force dut.cycle_count_q = 32'hFFFF_FFFF;
        count_adj = 32'hFFFF_FFFF - exp_count;
        @(posedge clk);
        #1 release dut.cycle_count_q;
        check_en = 1'b1;
        @(negedge clk);
        chk("wrap_preload", cycle_count, 32'hFFFF_FFFF);
        issue(1'b1, 1'b0, ROM_BASE, 8'h00);
        wait_rsp();
        chk("wrap_count", cycle_count, 32'h0000_0000);
        chk("wrap_rdata", 32'(rsp_rdata), 32'hA9);
        repeat (DIV) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
